// File: rtl/vga_sync_monitor.sv
// Recovers pixel coordinates from an hsync/vsync/blank raster and checks line/frame timing.
// Latency: rx_* one cycle after the sampled pixel; status pulses one cycle after the sync edge.
module vga_sync_monitor #(
   parameter int H_TOTAL         = 800,
   parameter int V_TOTAL         = 525,
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic        clk25,
   input  logic        reset_n,
   input  logic        hs,
   input  logic        vs,
   input  logic        blank,
   output logic [9:0]  rx_x,
   output logic [9:0]  rx_y,
   output logic        rx_valid,
   output logic        locked,
   output logic        frame_done,
   output logic        err,
   output logic [7:0]  err_count,
   output logic [10:0] meas_h_total,
   output logic [10:0] meas_v_total
);

   localparam logic       SYNC_ON = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic [10:0] CNT_MAX = 11'h7FF;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      state_q;
   logic        hs_q, vs_q, blank_q;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] col_q, col_d;
   logic [10:0] line_cnt_q, line_cnt_d;
   logic [10:0] meas_h_q, meas_h_d;
   logic [10:0] meas_v_q, meas_v_d;
   logic [9:0]  rx_x_q, rx_x_d;
   logic [9:0]  rx_y_q, rx_y_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_bad_q, frame_bad_d;
   logic        hs_seen_q, hs_seen_d;
   logic [7:0]  good_cnt_q;
   logic        locked_q, frame_done_q, err_q;
   logic [7:0]  err_count_q;

   logic        hs_lead, vs_lead, blank_rise;
   logic        timeout, y_sat;
   logic        line_err, width_err, ysat_err, bad_now, frame_good;
   logic [10:0] h_len, lines_now, act_now, col_start;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   // Edges compare the live input against its registered copy.
   always_comb begin
      hs_lead    = (hs == SYNC_ON) && (hs_q != SYNC_ON);
      vs_lead    = (vs == SYNC_ON) && (vs_q != SYNC_ON);
      blank_rise = blank && !blank_q;
      timeout    = (h_cnt_q == CNT_MAX);
      h_len      = timeout ? CNT_MAX : h_cnt_q + 11'd1;
      y_sat      = (rx_y_q == 10'h3FF);

      line_err   = hs_lead && hs_seen_q && (state_q != SEARCH) && (h_len != 11'(H_TOTAL));
      width_err  = blank_rise && (col_q != 11'(H_ACTIVE));
      ysat_err   = blank_rise && y_sat;
      bad_now    = frame_bad_q || line_err || width_err || ysat_err;

      // An hs edge or line end landing on the vs edge belongs to the frame that is ending.
      lines_now  = (hs_lead && line_cnt_q != CNT_MAX) ? line_cnt_q + 11'd1 : line_cnt_q;
      act_now    = {1'b0, rx_y_q} + 11'(blank_rise && !y_sat);
      frame_good = !bad_now && (lines_now == 11'(V_TOTAL)) && (act_now == 11'(V_ACTIVE));
   end

   always_comb begin
      h_cnt_d     = hs_lead ? 11'd0 : h_len;
      meas_h_d    = hs_lead ? h_len : meas_h_q;
      hs_seen_d   = (state_q == SEARCH) ? 1'b0 : (hs_seen_q || hs_lead);

      col_start   = (hs_lead || blank_rise) ? 11'd0 : col_q;
      col_d       = col_start;
      rx_x_d      = 10'd0;
      rx_valid_d  = 1'b0;
      if (!blank) begin
         col_d      = (col_start == CNT_MAX) ? CNT_MAX : col_start + 11'd1;
         rx_x_d     = (col_start > 11'd1023) ? 10'h3FF : col_start[9:0];
         rx_valid_d = 1'b1;
      end

      rx_y_d = rx_y_q;
      if (blank_rise && !y_sat) begin
         rx_y_d = rx_y_q + 10'd1;
      end
      if (vs_lead) begin
         rx_y_d = 10'd0;
      end

      line_cnt_d  = vs_lead ? 11'd0 : lines_now;
      meas_v_d    = vs_lead ? lines_now : meas_v_q;
      frame_bad_d = vs_lead ? 1'b0 : bad_now;
   end

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         blank_q     <= 1'b0;
         h_cnt_q     <= '0;
         col_q       <= '0;
         line_cnt_q  <= '0;
         meas_h_q    <= '0;
         meas_v_q    <= '0;
         rx_x_q      <= '0;
         rx_y_q      <= '0;
         rx_valid_q  <= 1'b0;
         frame_bad_q <= 1'b0;
         hs_seen_q   <= 1'b0;
      end else begin
         hs_q        <= hs;
         vs_q        <= vs;
         blank_q     <= blank;
         h_cnt_q     <= h_cnt_d;
         col_q       <= col_d;
         line_cnt_q  <= line_cnt_d;
         meas_h_q    <= meas_h_d;
         meas_v_q    <= meas_v_d;
         rx_x_q      <= rx_x_d;
         rx_y_q      <= rx_y_d;
         rx_valid_q  <= rx_valid_d;
         frame_bad_q <= frame_bad_d;
         hs_seen_q   <= hs_seen_d;
      end
   end

   // A saturated line counter means hs has vanished; that outranks any vs edge.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= SEARCH;
         good_cnt_q   <= '0;
         locked_q     <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         err_count_q  <= '0;
      end else begin
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         case (state_q)
            SEARCH: begin
               if (!timeout && vs_lead) begin
                  state_q    <= MEASURE;
                  good_cnt_q <= '0;
               end
            end
            MEASURE: begin
               if (timeout) begin
                  state_q <= SEARCH;
               end else if (vs_lead) begin
                  frame_done_q <= 1'b1;
                  if (frame_good) begin
                     if (good_cnt_q + 8'd1 >= 8'(LOCK_FRAMES)) begin
                        state_q    <= LOCKED;
                        locked_q   <= 1'b1;
                        good_cnt_q <= '0;
                     end else begin
                        good_cnt_q <= good_cnt_q + 8'd1;
                     end
                  end else begin
                     good_cnt_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (timeout) begin
                  state_q     <= SEARCH;
                  locked_q    <= 1'b0;
                  err_q       <= 1'b1;
                  err_count_q <= sat_inc8(err_count_q);
               end else if (vs_lead) begin
                  frame_done_q <= 1'b1;
                  if (!frame_good) begin
                     state_q     <= MEASURE;
                     good_cnt_q  <= '0;
                     locked_q    <= 1'b0;
                     err_q       <= 1'b1;
                     err_count_q <= sat_inc8(err_count_q);
                  end
               end
            end
            default: begin
               state_q  <= SEARCH;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx_x         = rx_x_q;
   assign rx_y         = rx_y_q;
   assign rx_valid     = rx_valid_q;
   assign locked       = locked_q;
   assign frame_done   = frame_done_q;
   assign err          = err_q;
   assign err_count    = err_count_q;
   assign meas_h_total = meas_h_q;
   assign meas_v_total = meas_v_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a scaled-down raster (48x20 total, 32x14 visible).
module tb_vga_sync_monitor;

   localparam int H        = 48;
   localparam int HA       = 32;
   localparam int HS_START = 36;
   localparam int HS_W     = 6;
   localparam int V        = 20;
   localparam int VA       = 14;
   localparam int VS_LINE  = 16;

   logic        clk25 = 1'b0;
   logic        reset_n;
   logic        hs, vs, blank;
   logic [9:0]  rx_x, rx_y;
   logic        rx_valid, locked, frame_done, err;
   logic [7:0]  err_count;
   logic [10:0] meas_h_total, meas_v_total;

   always #5 clk25 = ~clk25;

   vga_sync_monitor #(
      .H_TOTAL(H), .V_TOTAL(V), .H_ACTIVE(HA), .V_ACTIVE(VA),
      .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
   ) dut (
      .clk25(clk25), .reset_n(reset_n), .hs(hs), .vs(vs), .blank(blank),
      .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid), .locked(locked),
      .frame_done(frame_done), .err(err), .err_count(err_count),
      .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } pix_t;

   typedef struct packed {
      logic        fd;
      logic        er;
      logic        lk;
      logic [7:0]  ec;
      logic [10:0] mv;
      logic        chk_mv;
   } ev_t;

   pix_t pix_q[$];
   ev_t  ev_q[$];
   pix_t pe;
   ev_t  ee;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   pix_en = 1'b0;
   bit   run = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic ev_t mk_ev(input logic fd, input logic er, input logic lk,
                                 input int ec, input int mv, input logic chk);
      ev_t e;
      e.fd = fd; e.er = er; e.lk = lk; e.ec = 8'(ec); e.mv = 11'(mv); e.chk_mv = chk;
      return e;
   endfunction

   // Monitor: consumes expectations whenever the DUT presents a pixel or a status pulse.
   always @(negedge clk25) begin
      if (run) begin
         if (rx_valid && pix_en) begin
            if (pix_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL pixel: unexpected rx_valid x=%0d y=%0d, none expected", rx_x, rx_y);
            end else begin
               pe = pix_q.pop_front();
               check("pixel_xy", {12'd0, rx_x, rx_y}, {12'd0, pe.x, pe.y});
            end
         end
         if (frame_done || err) begin
            if (ev_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL event: unexpected frame_done=%0b err=%0b", frame_done, err);
            end else begin
               ee = ev_q.pop_front();
               check("event{fd,err,lock,errcnt,mv}",
                     {9'd0, frame_done, err, locked, err_count, (ee.chk_mv ? meas_v_total : 11'd0)},
                     {9'd0, ee.fd, ee.er, ee.lk, ee.ec, (ee.chk_mv ? ee.mv : 11'd0)});
            end
         end
      end
   end

   task automatic cyc(input logic h, input logic v, input logic b);
      hs = h; vs = v; blank = b;
      @(posedge clk25); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_x"}, 32'(rx_x), 0);
      check({tag, "_rx_y"}, 32'(rx_y), 0);
      check({tag, "_rx_valid"}, 32'(rx_valid), 0);
      check({tag, "_locked"}, 32'(locked), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_err_count"}, 32'(err_count), 0);
      check({tag, "_meas_h"}, 32'(meas_h_total), 0);
      check({tag, "_meas_v"}, 32'(meas_v_total), 0);
   endtask

   // One raster frame; vs asserts for two lines starting at column vs_off of VS_LINE.
   task automatic frame(input int vs_off, input int short_line, input int rst_line,
                        input bit chk_pix, input bit push_ev, input ev_t ev);
      pix_en = chk_pix;
      if (push_ev) ev_q.push_back(ev);
      for (int ln = 0; ln < V; ln++) begin
         for (int x = 0; x < ((ln == short_line) ? H - 1 : H); x++) begin
            logic h_a, v_a, b;
            pix_t p;
            b   = !(ln < VA && x < HA);
            h_a = (x >= HS_START) && (x < HS_START + HS_W);
            v_a = (ln == VS_LINE && x >= vs_off) || (ln == VS_LINE + 1) ||
                  (ln == VS_LINE + 2 && x < vs_off);
            if (!b && chk_pix) begin
               p.x = 10'(x); p.y = 10'(ln);
               pix_q.push_back(p);
            end
            if (short_line >= 0 && ln == short_line + 1 && x == HS_START + 2)
               check("meas_h_short_line", 32'(meas_h_total), H - 1);
            if (rst_line >= 0 && ln == rst_line && x == 40) begin
               reset_n = 1'b0;
               #1;
               check_all_zero("midreset");
            end
            if (rst_line >= 0 && ln == rst_line && x == 42) reset_n = 1'b1;
            cyc(!h_a, !v_a, b);
         end
      end
   endtask

   initial begin
      ev_t none;
      none = mk_ev(0, 0, 0, 0, 0, 0);
      hs = 1'b1; vs = 1'b1; blank = 1'b1; reset_n = 1'b0;
      repeat (3) @(posedge clk25);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      repeat (4) cyc(1'b1, 1'b1, 1'b1);

      // Nominal raster: first vs enters MEASURE, lock after the third vs edge.
      frame(0, -1, -1, 1'b0, 1'b0, none);
      frame(0, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 0, 0, V, 1));
      frame(0, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 0, V, 1));
      frame(0, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 0, V, 1));
      check("nominal_locked", 32'(locked), 1);
      check("nominal_meas_h", 32'(meas_h_total), H);
      check("nominal_meas_v", 32'(meas_v_total), V);
      check("nominal_err_count", 32'(err_count), 0);

      // One line short by a clock while locked, then relock.
      frame(0, 5, -1, 1'b1, 1'b1, mk_ev(1, 1, 0, 1, V, 1));
      frame(0, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 0, 1, V, 1));
      frame(0, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 1, V, 1));
      check("relock_after_short", 32'(locked), 1);

      // hs disappears while locked: timeout error, back to SEARCH.
      ev_q.push_back(mk_ev(0, 1, 0, 2, 0, 0));
      repeat (2100) cyc(1'b1, 1'b1, 1'b1);
      check("timeout_locked", 32'(locked), 0);
      check("timeout_err_count", 32'(err_count), 2);

      // Resume with vs coincident with hs.
      frame(HS_START, -1, -1, 1'b1, 1'b0, none);
      frame(HS_START, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 0, 2, V, 1));
      frame(HS_START, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 2, V, 1));
      frame(HS_START, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 2, V, 1));

      // Reset mid-frame while locked; relock with vs shifted within its line.
      frame((HS_START + 24) % H, -1, 3, 1'b0, 1'b0, none);
      frame((HS_START + 24) % H, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 0, 0, V, 1));
      frame((HS_START + 24) % H, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 0, V, 1));
      frame((HS_START + 24) % H, -1, -1, 1'b1, 1'b1, mk_ev(1, 0, 1, 0, V, 1));

      repeat (5) cyc(1'b1, 1'b1, 1'b1);
      check("events_outstanding", 32'(ev_q.size()), 0);
      check("pixels_outstanding", 32'(pix_q.size()), 0);
      check("final_locked", 32'(locked), 1);
      check("final_err_count", 32'(err_count), 0);
      check("final_meas_h", 32'(meas_h_total), H);
      check("final_meas_v", 32'(meas_v_total), V);
      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receiving end of the VGA timing interface: takes the hsync/vsync/blank triple produced by the pixel-timing generator and recovers the pixel coordinates from it.
- Measures line and frame timing against nominal values and reports lock and error status.
- Sits on clk25 beside the timing generator.
- Used for on-board self-test of the display path and for testbench checking of any raster source.

Parameters:
- H_TOTAL, 800, expected clocks per line (hsync leading edge to the next leading edge)
- V_TOTAL, 525, expected hsync leading edges per frame
- H_ACTIVE, 640, expected non-blank pixels per active line
- V_ACTIVE, 480, expected active lines per frame
- SYNC_ACTIVE_LOW, 1, 1 means hs/vs assert low; 0 means they assert high
- LOCK_FRAMES, 2, consecutive good frames required to enter LOCKED

Ports:
- clk25  in  1  pixel clock; all inputs are synchronous to it
- reset_n  in  1  asynchronous, active-low reset
- hs  in  1  horizontal sync from the timing generator
- vs  in  1  vertical sync from the timing generator
- blank  in  1  1 = outside the visible area
- rx_x  out  10  recovered column of the pixel sampled one cycle earlier
- rx_y  out  10  recovered active-line index
- rx_valid  out  1  rx_x/rx_y refer to a visible pixel
- locked  out  1  timing matches the parameters
- frame_done  out  1  one-cycle pulse at each evaluated vsync leading edge
- err  out  1  one-cycle pulse on loss of lock
- err_count  out  8  saturating count of lock losses
- meas_h_total  out  11  last measured line length
- meas_v_total  out  11  last measured lines per frame

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - State = SEARCH.
  - Internal counters, flags and edge registers cleared.
- Edge detection:
  - hs, vs and blank are registered once.
  - A leading edge is the transition into the asserted level, with polarity set by SYNC_ACTIVE_LOW.
  - A blank falling edge is line-active start; a blank rising edge is line-active end.
- Horizontal measurement:
  - h_cnt is 11 bits, saturates at 2047, and increments every cycle.
  - On an hs leading edge: meas_h_total <= h_cnt+1, then h_cnt <= 0.
  - The line-length check is made only once an hs edge has been seen since leaving SEARCH.
  - Length ≠ H_TOTAL sets the frame_bad flag.
- Pixel recovery:
  - An input sample with blank=0 in cycle t produces rx_valid=1 in cycle t+1.
  - In that cycle rx_x = number of non-blank samples earlier in the same line; the first visible pixel gives 0.
  - The column counter clears on blank rising edge and on hs leading edge.
  - On blank rising edge: active width ≠ H_ACTIVE sets frame_bad, and rx_y increments.
  - rx_y clears on vs leading edge.
  - Active lines beyond 1023 saturate rx_y and set frame_bad.
- Frame measurement:
  - line_cnt (11 bits, saturating) counts hs leading edges strictly after the previous vs edge, up to and including the current vs edge.
  - An hs edge coincident with a vs edge is counted in the frame that is ending.
  - At each vs leading edge: meas_v_total <= line_cnt.
  - The frame is good iff frame_bad=0, line_cnt=V_TOTAL and active line count=V_ACTIVE.
  - After the evaluation, the counters and frame_bad are cleared.
- State machine:
  - SEARCH:
    - Ignores content.
    - On first vs leading edge → MEASURE, with good_cnt=0 and no frame_done.
  - MEASURE:
    - Each vs edge pulses frame_done.
    - Good frame: good_cnt+1; on reaching LOCK_FRAMES → LOCKED, with locked=1 in the following cycle.
    - Bad frame: good_cnt=0, stay in MEASURE, no err.
  - LOCKED:
    - Each vs edge pulses frame_done.
    - Bad frame: err pulse, err_count+1, locked=0, → MEASURE with good_cnt=0.
- Timeout:
  - h_cnt reaching 2047 in any state → SEARCH.
  - If this happens in LOCKED, it also pulses err and increments err_count.
- err_count:
  - Saturates at 255.
  - Cleared only by reset.
- rx_valid is produced in every state; locked qualifies whether it can be trusted.
- Reset asserted mid-frame clears everything immediately. After release, the monitor waits in SEARCH for the next vs edge.

Test Plan:
- Nominal 800x525 raster (640x480 visible), 4 frames → first vs edge enters MEASURE. frame_done pulses at vs edges 2, 3 and 4. locked=1 the cycle after the 3rd vs edge. meas_h_total=800, meas_v_total=525, err_count=0.
- Pixel recovery while locked → first visible pixel gives rx_x=0, rx_y=0, rx_valid=1 one cycle after sampling. Last visible pixel gives rx_x=639, rx_y=479. rx_valid=0 throughout blanking.
- While locked, one line shortened to 799 clocks → meas_h_total=799 after that line. At the next vs edge: err pulse, err_count=1, locked=0. Relock after 2 further good frames.
- hs held deasserted while locked → after 2047 cycles: err pulse, err_count+1, state SEARCH. Resume timing: locked again after 1 + LOCK_FRAMES vs edges.
- hs and vs leading edges coincident every frame → meas_v_total=525 and locked asserts. Then shift vs by 400 clocks within its line → still locks; meas_v_total stays 525.
- reset_n pulsed low mid-frame while locked → all outputs 0 immediately, err_count=0. Relock sequence identical to the nominal case.
